// File: rtl/ptr_ecc_pkg.sv
// Shared SECDED helpers for protected pointer/status words.
// Both the encoder and the decoder use these helpers so that they agree on the codeword layout.
package ptr_ecc_pkg;

  typedef enum logic [1:0] {ECC_CLEAN, ECC_SEC, ECC_DED} ecc_class_e;

  // Smallest p with 2^p >= data_w + p + 1
  function automatic int unsigned calc_par_w(input int unsigned data_w);
    int unsigned p;
    p = 1;
    for (int unsigned k = 0; k < 8; k++)
      if ((32'd1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  function automatic bit is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Hamming position (1-based) of payload bit i
  function automatic int unsigned data_pos(input int unsigned i);
    int unsigned pos;
    int unsigned cnt;
    pos = 0;
    cnt = 0;
    for (int unsigned p = 1; p < 64; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == i && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ptr_ecc_syndrome.sv
// Combinational Hamming syndrome and overall parity of one codeword.
module ptr_ecc_syndrome
  import ptr_ecc_pkg::*;
#(
  parameter  int unsigned DATA_W = 10,
  localparam int unsigned PAR_W  = calc_par_w(DATA_W),
  localparam int unsigned ENC_W  = DATA_W + PAR_W + 1
) (
  input  logic [ENC_W-1:0] i_enc,
  output logic [PAR_W-1:0] o_syn,
  output logic             o_par
);

  always_comb begin
    o_syn = '0;
    for (int unsigned pos = 1; pos < ENC_W; pos++)
      if (i_enc[pos-1]) o_syn = o_syn ^ PAR_W'(pos);
  end

  assign o_par = ^i_enc;

endmodule

// File: rtl/ptr_secded_decode.sv
// Two-stage valid/ready SECDED decoder with saturating error statistics.
module ptr_secded_decode
  import ptr_ecc_pkg::*;
#(
  parameter  int unsigned DATA_W   = 10,
  parameter  bit          DATA_INV = 1'b1,
  parameter  int unsigned CNT_W    = 8,
  localparam int unsigned PAR_W    = calc_par_w(DATA_W),
  localparam int unsigned ENC_W    = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ENC_W-1:0]  in_enc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [PAR_W-1:0]  out_syn,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt,
  output logic              ded_sticky
);

  localparam int unsigned NPOS = DATA_W + PAR_W;

  logic              r_s1_valid;
  logic [ENC_W-1:0]  r_s1_enc;
  logic [PAR_W-1:0]  r_s1_syn;
  logic              r_s1_par;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sec;
  logic              r_out_ded;
  logic [PAR_W-1:0]  r_out_syn;
  logic [CNT_W-1:0]  r_sec_cnt;
  logic [CNT_W-1:0]  r_ded_cnt;
  logic              r_ded_sticky;

  logic              w_s1_en;
  logic              w_s2_en;
  logic              w_out_hs;
  logic [PAR_W-1:0]  w_syn;
  logic              w_par;
  logic [ENC_W-1:0]  w_fix;
  logic [DATA_W-1:0] w_data;
  ecc_class_e        w_class;

  assign w_s2_en  = !r_out_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign w_out_hs = r_out_valid && out_ready;

  ptr_ecc_syndrome #(.DATA_W(DATA_W)) u_syn (
    .i_enc (in_enc),
    .o_syn (w_syn),
    .o_par (w_par)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_enc   <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_enc <= in_enc;
        r_s1_syn <= w_syn;
        r_s1_par <= w_par;
      end
    end
  end

  // Overall-parity-only errors (s=0, P=1) count as corrected with data untouched
  always_comb begin
    w_class = ECC_CLEAN;
    w_fix   = r_s1_enc;
    if (r_s1_par) begin
      if (r_s1_syn == '0) begin
        w_class = ECC_SEC;
      end else if (32'(r_s1_syn) > NPOS) begin
        w_class = ECC_DED;
      end else begin
        w_class = ECC_SEC;
        for (int unsigned pos = 1; pos <= NPOS; pos++)
          if (r_s1_syn == PAR_W'(pos)) w_fix[pos-1] = ~w_fix[pos-1];
      end
    end else if (r_s1_syn != '0) begin
      w_class = ECC_DED;
    end
  end

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext
    localparam int unsigned POS = data_pos(gi);
    assign w_data[gi] = w_fix[POS-1] ^ DATA_INV;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sec   <= 1'b0;
      r_out_ded   <= 1'b0;
      r_out_syn   <= '0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_data;
        r_out_sec  <= (w_class == ECC_SEC);
        r_out_ded  <= (w_class == ECC_DED);
        r_out_syn  <= r_s1_syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      r_sec_cnt    <= '0;
      r_ded_cnt    <= '0;
      r_ded_sticky <= 1'b0;
    end else if (w_out_hs) begin
      if (r_out_sec && r_sec_cnt != '1) r_sec_cnt <= r_sec_cnt + 1'b1;
      if (r_out_ded && r_ded_cnt != '1) r_ded_cnt <= r_ded_cnt + 1'b1;
      if (r_out_ded) r_ded_sticky <= 1'b1;
    end
  end

  assign in_ready   = w_s1_en;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_sec    = r_out_sec;
  assign out_ded    = r_out_ded;
  assign out_syn    = r_out_syn;
  assign sec_cnt    = r_sec_cnt;
  assign ded_cnt    = r_ded_cnt;
  assign ded_sticky = r_ded_sticky;

endmodule

// File: doc/ptr_secded_decode.md
# ptr_secded_decode

Parametrised, pipelined SECDED (single-error-correct, double-error-detect) decoder for protected FIFO pointers and status words. It generalises the fixed 10-bit Hamming pointer decoder to any data width and adds an overall parity bit for double-error detection. It also adds a two-stage valid/ready pipeline and saturating error-statistics counters. It sits between the protected pointer registers and the FIFO full/empty comparison logic.

## Interface
- DATA_W, 10, payload width in bits (2..57)
- PAR_W, derived: smallest p with 2^p >= DATA_W+p+1 (4 for DATA_W=10); not user-overridable
- ENC_W, derived: DATA_W+PAR_W+1
- DATA_INV, 1, 1 = payload bits are stored inverted in the codeword (codebase pointer convention); 0 = stored true
- CNT_W, 8, width of each error counter
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  codeword valid
- in_ready  out  1  decoder can accept a codeword
- in_enc  in  ENC_W  encoded word
- out_valid  out  1  decoded result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  DATA_W  corrected payload, true polarity
- out_sec  out  1  single error detected and corrected
- out_ded  out  1  uncorrectable error; out_data is uncorrected
- out_syn  out  PAR_W  raw syndrome: 0 = none, else Hamming position (1-based)
- cnt_clr  in  1  synchronous clear of counters and sticky flag
- sec_cnt  out  CNT_W  saturating count of delivered SEC results
- ded_cnt  out  CNT_W  saturating count of delivered DED results
- ded_sticky  out  1  set on any delivered DED result; held until cnt_clr or reset

## Operation
- Codeword layout: Hamming positions 1..DATA_W+PAR_W map to in_enc[pos-1].
  - Parity bits sit at power-of-two positions.
  - Payload bits fill the remaining positions in ascending order, LSB first.
  - in_enc[ENC_W-1] is overall even parity over in_enc[ENC_W-2:0].
- Syndrome bit k = XOR of all in_enc[pos-1] whose pos has bit k set. Overall check P = XOR of all ENC_W bits.
- Classification:
  - s=0, P=0: clean.
  - P=1, s=0: error in the overall-parity bit. Result is out_sec=1 and the data is unchanged.
  - P=1, 1 <= s <= DATA_W+PAR_W: flip position s, then out_sec=1.
  - P=1, s > DATA_W+PAR_W: treat as out_ded=1.
  - P=0, s != 0: out_ded=1. Data is extracted without correction.
- If DATA_INV=1, extracted payload bits are inverted after correction.
- Counters:
  - sec_cnt/ded_cnt increment on an output handshake (out_valid && out_ready) carrying the matching flag.
  - Counters saturate at 2^CNT_W-1.
  - cnt_clr in the same cycle as an increment leaves the counter at 0; clear wins.
  - ded_sticky follows the same rule.

## Timing
- Stage 1 registers in_enc, syndrome and P. Stage 2 registers out_data, out_sec, out_ded and out_syn.
- Latency is 2 cycles from input handshake to out_valid, when there is no backpressure.
- Throughput is 1 word/cycle.
- Stage enables: s2_en = !s2_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en. in_ready is combinational from out_ready.
- Under stall, outputs and stage contents hold stable. No word is dropped or duplicated.
- out_* payload fields are don't-care when out_valid=0.
- Reset values:
  - s1_valid, out_valid: 0.
  - out_data, out_syn, out_sec, out_ded: 0.
  - sec_cnt, ded_cnt, ded_sticky: 0.
- in_ready is 1 during the first cycle after reset.
- Reset mid-operation discards both stages. Counters are not updated for discarded words.

## Structure
- Package ptr_ecc_pkg holds:
  - function calc_par_w(data_w);
  - function data_pos(i), returning the Hamming position of payload bit i;
  - function is_pow2(pos);
  - a class enum {ECC_CLEAN, ECC_SEC, ECC_DED}.
- The matching encoder must use the same package.
- One sub-module, ptr_ecc_syndrome: combinational, computes syndrome and P from an ENC_W word. It is reusable by the encoder self-check.

## Test plan
- Encode DATA_W=10 payload 10'h2A5 with the package reference model (DATA_INV=1). Apply it with out_ready=1.
  - Required: out_data=10'h2A5, out_sec=0, out_ded=0, out_syn=0, 2 cycles after the input handshake.
- Flip in_enc[5] (position 6) of that word.
  - Required: out_data=10'h2A5, out_sec=1, out_syn=6, sec_cnt=1.
- Flip in_enc[14] (the overall-parity bit) only.
  - Required: out_data=10'h2A5, out_sec=1, out_syn=0.
- Flip in_enc[2] and in_enc[9].
  - Required: out_ded=1, out_data uncorrected, ded_cnt=1, ded_sticky=1.
- Backpressure: stream 8 words with out_ready toggling 1,0,0,1 repeated.
  - Required: all 8 results delivered in order.
  - Required: in_ready=0 exactly when both stages are full and out_ready=0.
- Counters: CNT_W=2, send 5 SEC words.
  - Required: sec_cnt saturates at 3.
- cnt_clr asserted on the same cycle as a SEC delivery.
  - Required: sec_cnt=0.
- Assert rst_n=0 mid-stream.
  - Required: out_valid=0 on the next cycle, with no counter change.
